// File: rtl/sign_mag_pkg.sv
// Shared types for the sign_mag_pipe slice: per-word mode, stage payload and
// saturation limit helper.
package sign_mag_pkg;

  // Widest data path any instance may use; stage payloads carry this many bits.
  localparam int unsigned SM_MAX_W = 64;

  typedef enum logic {
    MODE_2C_TO_SM = 1'b0,
    MODE_SM_TO_2C = 1'b1
  } mode_e;

  typedef struct packed {
    mode_e                 mode;
    logic                  sign;
    logic [SM_MAX_W-1:0]   data;
    logic                  sat_en;
  } sm_word_t;

  typedef struct packed {
    logic [SM_MAX_W-1:0] smax;
    logic [SM_MAX_W-1:0] smin;
  } sm_limits_t;

  // Most positive (011..1) and most negative (100..0) patterns for a width.
  function automatic sm_limits_t sm_sat_limits(input int unsigned width);
    sm_limits_t l;
    l.smin = SM_MAX_W'(1) << (width - 1);
    l.smax = l.smin - SM_MAX_W'(1);
    return l;
  endfunction

endpackage

// File: rtl/sign_mag_core.sv
// Combinational sign-magnitude <-> two's-complement conversion of one stage
// payload word.
module sign_mag_core
  import sign_mag_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  sm_word_t         w,
  output logic             sign,
  output logic [WIDTH-1:0] data,
  output logic             ovf,
  output logic             negzero
);

  localparam sm_limits_t LIM = sm_sat_limits(WIDTH);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] neg_d;
  logic             unused_bits;

  assign d           = w.data[WIDTH-1:0];
  assign neg_d       = -d;
  assign unused_bits = ^{w.data, LIM.smax, LIM.smin};

  always_comb begin
    sign    = 1'b0;
    data    = '0;
    ovf     = 1'b0;
    negzero = 1'b0;
    if (w.mode == MODE_2C_TO_SM) begin
      sign = d[WIDTH-1];
      data = sign ? neg_d : d;
    end else begin
      // Negative side reaches one further: -L is representable, +L is not.
      ovf     = w.sign ? (d[WIDTH-1] && (d[WIDTH-2:0] != '0)) : d[WIDTH-1];
      negzero = w.sign && (d == '0);
      if (ovf && w.sat_en)
        data = w.sign ? LIM.smin[WIDTH-1:0] : LIM.smax[WIDTH-1:0];
      else
        data = w.sign ? neg_d : d;
      sign = data[WIDTH-1];
    end
  end

endmodule

// File: rtl/sign_mag_pipe.sv
// Two-stage valid/ready sign-magnitude / two's-complement converter.
// Optional output statistics counters when SIGN_MAG_PIPE_STATS_EN is defined.
module sign_mag_pipe
  import sign_mag_pkg::*;
#(
  parameter int unsigned WIDTH          = 6,
  parameter bit          SAT_EN_DEFAULT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sat_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic             in_sign,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_negzero
`ifdef SIGN_MAG_PIPE_STATS_EN
  ,
  output logic [15:0]      neg_count,
  output logic [15:0]      ovf_count
`endif
);

  logic             v1;
  logic             v2;
  logic             adv2;
  sm_word_t         s1;
  logic             c_sign;
  logic [WIDTH-1:0] c_data;
  logic             c_ovf;
  logic             c_negzero;

  assign adv2      = !v2 || out_ready;
  assign in_ready  = !v1 || adv2;
  assign out_valid = v2;

  sign_mag_core #(.WIDTH(WIDTH)) u_core (
    .w       (s1),
    .sign    (c_sign),
    .data    (c_data),
    .ovf     (c_ovf),
    .negzero (c_negzero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      s1.mode     <= MODE_2C_TO_SM;
      s1.sign     <= 1'b0;
      s1.data     <= '0;
      s1.sat_en   <= SAT_EN_DEFAULT;
      out_mode    <= 1'b0;
      out_sign    <= 1'b0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_negzero <= 1'b0;
    end else begin
      // in_ready implies stage 1 is either empty or moving on this edge.
      if (in_ready)
        v1 <= in_valid;
      if (in_valid && in_ready) begin
        s1.mode   <= mode_e'(in_mode);
        s1.sign   <= in_sign;
        s1.data   <= SM_MAX_W'(in_data);
        s1.sat_en <= sat_en;
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          out_mode    <= s1.mode;
          out_sign    <= c_sign;
          out_data    <= c_data;
          out_ovf     <= c_ovf;
          out_negzero <= c_negzero;
        end
      end
    end
  end

`ifdef SIGN_MAG_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      neg_count <= '0;
      ovf_count <= '0;
    end else if (out_valid && out_ready) begin
      if (out_sign && (neg_count != '1))
        neg_count <= neg_count + 16'd1;
      if (out_ovf && (ovf_count != '1))
        ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sign_mag_pipe.sv
// Randomized self-checking bench for sign_mag_pipe against an arithmetic
// reference model and an in-order scoreboard.
module tb_sign_mag_pipe;

  localparam int W = 6;
  localparam int L = 1 << (W - 1);
  localparam int M = 1 << W;

  typedef struct packed {
    logic         mode;
    logic         sign;
    logic [W-1:0] data;
    logic         ovf;
    logic         nz;
  } exp_t;

  typedef struct {
    exp_t e;
    int   c;
  } sb_t;

  logic         clk;
  logic         reset;
  logic         sat_en;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic         in_sign;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_mode;
  logic         out_sign;
  logic [W-1:0] out_data;
  logic         out_ovf;
  logic         out_negzero;
`ifdef SIGN_MAG_PIPE_STATS_EN
  logic [15:0]  neg_count;
  logic [15:0]  ovf_count;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   neg_m    = 0;
  int   ovf_m    = 0;
  bit   chk_lat  = 0;
  bit   rnd_rdy  = 0;
  bit   hold     = 0;
  exp_t held;
  sb_t  sbq[$];

  sign_mag_pipe #(.WIDTH(W), .SAT_EN_DEFAULT(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .sat_en      (sat_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_sign     (in_sign),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mode    (out_mode),
    .out_sign    (out_sign),
    .out_data    (out_data),
    .out_ovf     (out_ovf),
    .out_negzero (out_negzero)
`ifdef SIGN_MAG_PIPE_STATS_EN
    ,
    .neg_count   (neg_count),
    .ovf_count   (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: interpret the word as an integer and re-encode it.
  function automatic exp_t model(input logic m, input logic s, input logic [W-1:0] d,
                                 input logic sat);
    exp_t e;
    int   v;
    int   r;
    e.mode = m;
    if (!m) begin
      v      = (int'(d) >= L) ? int'(d) - M : int'(d);
      e.sign = (v < 0);
      e.data = W'((v < 0) ? -v : v);
      e.ovf  = 1'b0;
      e.nz   = 1'b0;
    end else begin
      v     = s ? -int'(d) : int'(d);
      e.nz  = s && (d == '0);
      e.ovf = (v > L - 1) || (v < -L);
      if (e.ovf && sat)
        v = (v > 0) ? L - 1 : -L;
      r      = ((v % M) + M) % M;
      e.data = W'(r);
      e.sign = e.data[W-1];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    sb_t  it;
    exp_t now;
    cyc++;
    now = '{mode: out_mode, sign: out_sign, data: out_data, ovf: out_ovf, nz: out_negzero};
    if (reset) begin
      sbq.delete();
      hold  = 0;
      neg_m = 0;
      ovf_m = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_fields", now, held);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_depth", sbq.size(), 1);
        end else begin
          it = sbq.pop_front();
          chk("out_mode", out_mode, it.e.mode);
          chk("out_sign", out_sign, it.e.sign);
          chk("out_data", out_data, it.e.data);
          chk("out_ovf", out_ovf, it.e.ovf);
          chk("out_negzero", out_negzero, it.e.nz);
          if (chk_lat)
            chk("latency", cyc - it.c, 2);
          if (it.e.sign && neg_m < 16'hFFFF) neg_m++;
          if (it.e.ovf && ovf_m < 16'hFFFF) ovf_m++;
        end
      end
      if (in_valid && in_ready) begin
        it.e = model(in_mode, in_sign, in_data, sat_en);
        it.c = cyc;
        sbq.push_back(it);
      end
      hold = out_valid && !out_ready;
      held = now;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy)
        out_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic send(input logic m, input logic s, input logic [W-1:0] d, input logic sat,
                      output int waits);
    logic acc;
    waits    = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    in_sign  = s;
    in_data  = d;
    sat_en   = sat;
    while (!acc && waits < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc)
      chk("send_timeout", waits, 0);
  endtask

  task automatic drain();
    int t;
    t        = 0;
    in_valid = 1'b0;
    while (sbq.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_fields", {out_mode, out_sign, out_data, out_ovf, out_negzero}, 0);
`ifdef SIGN_MAG_PIPE_STATS_EN
    chk("rst_neg_count", neg_count, 0);
    chk("rst_ovf_count", ovf_count, 0);
`endif
  endtask

  initial begin
    int           waits;
    logic [W-1:0] strm [5];
    logic [W-1:0] bp   [6];
    logic [W-1:0] d;
    logic         acc;
    int           idx;
    int           pick;

    strm = '{6'b101010, 6'b010111, 6'b111111, 6'b011111, 6'b000011};
    bp   = '{6'd3, 6'd60, 6'd32, 6'd17, 6'd1, 6'd45};

    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_sign = 1'b0;
    in_data = '0; sat_en = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_state();
    @(posedge clk);
    #1;

    // Back-to-back stream: no stalls, fixed two-cycle latency.
    chk_lat = 1;
    foreach (strm[i]) begin
      send(1'b0, 1'b0, strm[i], 1'b1, waits);
      chk("stream_stall", waits, 0);
    end
    send(1'b0, 1'b0, 6'b100000, 1'b1, waits);
    send(1'b1, 1'b0, 6'b100000, 1'b1, waits);
    send(1'b1, 1'b1, 6'b100001, 1'b1, waits);
    send(1'b1, 1'b1, 6'b100000, 1'b1, waits);
    send(1'b1, 1'b0, 6'b100000, 1'b0, waits);
    send(1'b1, 1'b1, 6'b000000, 1'b1, waits);
    send(1'b1, 1'b1, 6'b111111, 1'b0, waits);
    drain();
    chk_lat = 0;

    // Backpressure: only two words fit while the output is stalled.
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1; in_mode = 1'b0; in_sign = 1'b0; sat_en = 1'b1; in_data = bp[0];
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, (c < 2));
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        in_data = bp[idx];
      end
    end
    out_ready = 1'b1;
    for (int i = idx; i < 6; i++)
      send(1'b0, 1'b0, bp[i], 1'b1, waits);
    drain();

    // Random traffic with random output backpressure.
    rnd_rdy = 1;
    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(7);
      case (pick)
        0: d = '0;
        1: d = W'(L);
        2: d = W'(L + 1);
        3: d = W'(L - 1);
        4: d = '1;
        default: d = W'($urandom_range(M - 1));
      endcase
      send(1'($urandom_range(1)), 1'($urandom_range(1)), d, 1'($urandom_range(1)), waits);
      if ($urandom_range(4) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    rnd_rdy = 0;
    out_ready = 1'b1;
    drain();

`ifdef SIGN_MAG_PIPE_STATS_EN
    chk("neg_count", neg_count, neg_m);
    chk("ovf_count", ovf_count, ovf_m);
`endif

    // Reset with both stages full and a word offered in the reset cycle.
    out_ready = 1'b0;
    send(1'b1, 1'b1, 6'd40, 1'b1, waits);
    send(1'b1, 1'b0, 6'd40, 1'b1, waits);
    in_valid = 1'b1; in_data = 6'd7;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check_reset_state();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
